// File: rtl/armored40_rx_lock.sv
// Word-lock tracker behind the armored40 decoder: hunts for a run of clean words,
// requests bit slips on failures, and once locked forwards payload and keeps error statistics.
module armored40_rx_lock #(
  parameter int TARGET_CHIP = 2,
  parameter int LOCK_GOOD   = 16,
  parameter int UNLOCK_BAD  = 4,
  parameter int WINDOW      = 64,
  parameter int SLIP_WAIT   = 8
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [32:0] din,
  input  logic        din_valid,
  input  logic        din_fix,
  input  logic        din_fail,
  input  logic        clear_counts,
  output logic [31:0] dout,
  output logic        dout_ctrl,
  output logic        dout_valid,
  output logic        slip,
  output logic        locked,
  output logic [15:0] fix_count,
  output logic [15:0] fail_count,
  output logic [1:0]  dbg_state
);

  localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int BW = $clog2(UNLOCK_BAD + 1);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_HOLD = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  // Handshake: din/din_fix/din_fail are sampled only on edges where din_valid=1;
  // dout/dout_ctrl are meaningful only while dout_valid=1 and hold otherwise.
  // There is no backpressure: the block never stalls its input.

  state_t          r_state;
  logic [7:0]      r_good_cnt;
  logic [7:0]      r_slip_cnt;
  logic [WW-1:0]   r_win_cnt;
  logic [BW-1:0]   r_bad_cnt;
  logic [31:0]     r_dout;
  logic            r_dout_ctrl;
  logic            r_dout_valid;
  logic            r_slip;
  logic            r_locked;
  logic [15:0]     r_fix_count;
  logic [15:0]     r_fail_count;

  logic            w_good;
  logic            w_bad;
  logic [7:0]      w_good_next;
  logic [BW-1:0]   w_bad_next;
  logic            w_win_last;
  logic            w_unlock;
  logic            w_fix_inc;
  logic            w_fail_inc;
  logic            w_unused_chip;

  assign w_good        = din_valid & ~din_fail;
  assign w_bad         = din_valid & din_fail;
  assign w_good_next   = r_good_cnt + 8'd1;
  assign w_bad_next    = r_bad_cnt + 1'b1;
  assign w_win_last    = (r_win_cnt == WW'(WINDOW - 1));
  assign w_unlock      = w_bad & (w_bad_next == BW'(UNLOCK_BAD));
  assign w_fix_inc     = (r_state == ST_LOCKED) & w_good & din_fix;
  assign w_fail_inc    = (r_state == ST_LOCKED) & w_bad;
  assign w_unused_chip = (TARGET_CHIP == 0);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= ST_HUNT;
      r_good_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_win_cnt    <= '0;
      r_bad_cnt    <= '0;
      r_dout       <= '0;
      r_dout_ctrl  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_slip       <= 1'b0;
      r_locked     <= 1'b0;
      r_fix_count  <= '0;
      r_fail_count <= '0;
    end else begin
      r_slip       <= 1'b0;
      r_dout_valid <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_good) begin
            // The word completing the run only declares lock; it is not forwarded.
            if (w_good_next == 8'(LOCK_GOOD)) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_good_cnt <= '0;
              r_win_cnt  <= '0;
              r_bad_cnt  <= '0;
            end else begin
              r_good_cnt <= w_good_next;
            end
          end else if (w_bad) begin
            r_good_cnt <= '0;
            r_slip     <= 1'b1;
            r_slip_cnt <= '0;
            r_state    <= ST_SLIP_HOLD;
          end
        end
        ST_SLIP_HOLD: begin
          if (r_slip_cnt == 8'(SLIP_WAIT - 1)) begin
            r_state    <= ST_HUNT;
            r_good_cnt <= '0;
            r_slip_cnt <= '0;
          end else begin
            r_slip_cnt <= r_slip_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (w_unlock) begin
            // Loss of lock re-hunts at the current alignment, so no slip here.
            r_state    <= ST_HUNT;
            r_locked   <= 1'b0;
            r_win_cnt  <= '0;
            r_bad_cnt  <= '0;
            r_good_cnt <= '0;
          end else if (din_valid) begin
            if (w_good) begin
              r_dout       <= din[31:0];
              r_dout_ctrl  <= din[32];
              r_dout_valid <= 1'b1;
            end
            if (w_win_last) begin
              r_win_cnt <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              if (w_bad) r_bad_cnt <= w_bad_next;
            end
          end
        end
        default: begin
          r_state  <= ST_HUNT;
          r_locked <= 1'b0;
        end
      endcase

      if (clear_counts)
        r_fix_count <= '0;
      else if (w_fix_inc && (r_fix_count != 16'hFFFF))
        r_fix_count <= r_fix_count + 16'd1;

      if (clear_counts)
        r_fail_count <= '0;
      else if (w_fail_inc && (r_fail_count != 16'hFFFF))
        r_fail_count <= r_fail_count + 16'd1;
    end
  end

  assign dout       = r_dout;
  assign dout_ctrl  = r_dout_ctrl;
  assign dout_valid = r_dout_valid;
  assign slip       = r_slip;
  assign locked     = r_locked;
  assign fix_count  = r_fix_count;
  assign fail_count = r_fail_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_armored40_rx_lock.sv
// Directed and randomized bench for armored40_rx_lock against a cycle-level behavioural model.
module tb_armored40_rx_lock;

  localparam int LOCK_GOOD  = 16;
  localparam int UNLOCK_BAD = 4;
  localparam int WINDOW     = 64;
  localparam int SLIP_WAIT  = 8;

  logic        clk = 1'b0;
  logic        arst;
  logic [32:0] din;
  logic        din_valid;
  logic        din_fix;
  logic        din_fail;
  logic        clear_counts;
  logic [31:0] dout;
  logic        dout_ctrl;
  logic        dout_valid;
  logic        slip;
  logic        locked;
  logic [15:0] fix_count;
  logic [15:0] fail_count;
  logic [1:0]  dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 hunting, 1 waiting after a slip, 2 locked.
  int          m_mode;
  int          m_run;
  int          m_hold_left;
  int          m_win_pos;
  int          m_win_bad;
  int          e_fix;
  int          e_fail;
  logic        e_slip;
  logic        e_dv;
  logic        e_locked;
  logic [31:0] e_dout;
  logic        e_ctrl;

  armored40_rx_lock #(
    .TARGET_CHIP(2), .LOCK_GOOD(LOCK_GOOD), .UNLOCK_BAD(UNLOCK_BAD),
    .WINDOW(WINDOW), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk(clk), .arst(arst), .din(din), .din_valid(din_valid), .din_fix(din_fix),
    .din_fail(din_fail), .clear_counts(clear_counts), .dout(dout), .dout_ctrl(dout_ctrl),
    .dout_valid(dout_valid), .slip(slip), .locked(locked), .fix_count(fix_count),
    .fail_count(fail_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_hold_left = 0; m_win_pos = 0; m_win_bad = 0;
    e_fix = 0; e_fail = 0; e_slip = 1'b0; e_dv = 1'b0; e_locked = 1'b0;
    e_dout = '0; e_ctrl = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic f, input logic x,
                              input logic [32:0] d, input logic c);
    logic was_locked;
    logic good;
    logic bad;
    was_locked = (m_mode == 2);
    good = v && !f;
    bad  = v && f;
    e_slip = 1'b0;
    e_dv   = 1'b0;
    if (m_mode == 0) begin
      if (good) begin
        m_run++;
        if (m_run == LOCK_GOOD) begin
          m_mode = 2; m_run = 0; m_win_pos = 0; m_win_bad = 0;
        end
      end else if (bad) begin
        m_run = 0; e_slip = 1'b1; m_mode = 1; m_hold_left = SLIP_WAIT;
      end
    end else if (m_mode == 1) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_mode = 0; m_run = 0;
      end
    end else if (v) begin
      m_win_pos++;
      if (bad) m_win_bad++;
      if (good) begin
        e_dv = 1'b1; e_dout = d[31:0]; e_ctrl = d[32];
      end
      if (m_win_bad >= UNLOCK_BAD) begin
        m_mode = 0; m_run = 0;
      end
      if (m_win_pos == WINDOW || m_mode == 0) begin
        m_win_pos = 0; m_win_bad = 0;
      end
    end
    if (c) e_fix = 0;
    else if (was_locked && good && x && e_fix < 65535) e_fix++;
    if (c) e_fail = 0;
    else if (was_locked && bad && e_fail < 65535) e_fail++;
    e_locked = (m_mode == 2);
  endtask

  task automatic check_all(input string tag);
    vectors++;
    chk({tag, ".locked"}, 32'(locked), 32'(e_locked));
    chk({tag, ".slip"}, 32'(slip), 32'(e_slip));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_dv));
    chk({tag, ".dout"}, dout, e_dout);
    chk({tag, ".dout_ctrl"}, 32'(dout_ctrl), 32'(e_ctrl));
    chk({tag, ".fix_count"}, 32'(fix_count), 32'(e_fix));
    chk({tag, ".fail_count"}, 32'(fail_count), 32'(e_fail));
  endtask

  task automatic step(input string tag, input logic v, input logic f, input logic x,
                      input logic c);
    logic [32:0] d;
    d = {1'(($urandom() & 1)), $urandom()};
    din = d; din_valid = v; din_fail = f; din_fix = x; clear_counts = c;
    @(posedge clk);
    model_update(v, f, x, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic good_words(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'(($urandom_range(0, 3) == 0)), 1'b0);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge arrives.
  task automatic do_reset();
    #2 arst = 1'b1;
    #1 model_reset();
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #2 arst = 1'b0;
  endtask

  // One window while locked: bad words at the listed slots, idle gaps sprinkled between.
  task automatic window_with_bad(input string tag, input int nbad);
    for (int i = 0; i < WINDOW; i++) begin
      if ($urandom_range(0, 4) == 0) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      step(tag, 1'b1, 1'(i < nbad * 10 && i % 10 == 5), 1'(($urandom_range(0, 2) == 0)), 1'b0);
    end
  endtask

  initial begin
    arst = 1'b0; din = '0; din_valid = 1'b0; din_fix = 1'b0; din_fail = 1'b0;
    clear_counts = 1'b0;
    model_reset();
    do_reset();

    // Lock after 16 clean words; the 17th is the first forwarded word.
    good_words("acquire", LOCK_GOOD - 1);
    chk("acquire.not_yet", 32'(locked), 32'd0);
    good_words("acquire16", 1);
    chk("acquire.locked", 32'(locked), 32'd1);
    chk("acquire.no_output", 32'(dout_valid), 32'd0);
    good_words("first_out", 1);
    chk("first_out.valid", 32'(dout_valid), 32'd1);

    // Three failures per window keep lock across window boundaries.
    step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WINDOW - 1; i++)
      step("win_align", 1'b1, 1'b0, 1'b0, 1'b0);
    window_with_bad("win1", 3);
    chk("win1.locked", 32'(locked), 32'd1);
    window_with_bad("win2", 3);
    chk("win2.fail6", 32'(fail_count), 32'd6);

    // Fix flag on a failed word counts only as a failure.
    step("fixfail", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("fixfail.no_dv", 32'(dout_valid), 32'd0);

    // Remaining failures of this window break lock without a slip.
    for (int i = 0; i < 3; i++) step("unlock", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("unlock.locked", 32'(locked), 32'd0);
    chk("unlock.no_slip", 32'(slip), 32'd0);

    // Hunt: 10 good, 1 bad, slip, ignored hold window, then a fresh run of 16.
    good_words("hunt10", 10);
    step("hunt_bad", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hunt_bad.slip", 32'(slip), 32'd1);
    for (int i = 0; i < SLIP_WAIT; i++)
      step("hold", 1'(($urandom() & 1)), 1'(($urandom() & 1)), 1'b0, 1'b0);
    good_words("relock", LOCK_GOOD - 1);
    chk("relock.early", 32'(locked), 32'd0);
    good_words("relock16", 1);

    // Saturation of fix_count, then clear beats a simultaneous increment.
    step("sat_clr", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) step("sat", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sat.full", 32'(fix_count), 32'h0000FFFF);
    for (int i = 0; i < 3; i++) step("sat_hold", 1'b1, 1'b0, 1'b1, 1'b0);
    step("clr_vs_fix", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_vs_fix.zero", 32'(fix_count), 32'd0);

    // Reset in the middle of a slip hold cancels it.
    do_reset();
    step("rst_slip_bad", 1'b1, 1'b1, 1'b0, 1'b0);
    step("rst_slip_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    good_words("post_reset", LOCK_GOOD + 4);

    // Randomized traffic covering every mode and transition.
    for (int i = 0; i < 1500; i++)
      step("rand", 1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 14) == 0)),
           1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 60) == 0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/armored40_rx_lock.md
ARMORED40_RX_LOCK -- requirements
Module: armored40_rx_lock

Interface
REQ-001 Parameter TARGET_CHIP, default 2, device family selector passed through for consistency; no functional effect.
REQ-002 Parameter LOCK_GOOD, default 16, consecutive good words required to declare lock (range 2..255).
REQ-003 Parameter UNLOCK_BAD, default 4, failed words within one window that force loss of lock (range 1..WINDOW).
REQ-004 Parameter WINDOW, default 64, window length in valid words for the loss-of-lock check (range 2..1024).
REQ-005 Parameter SLIP_WAIT, default 8, clock cycles to ignore input after a slip request (range 1..255).
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 arst  input  1  reset, asynchronous and active-high.
REQ-008 din  input  33  descrambled word from the armored40 decoder; bit 32 is the control flag, bits 31:0 are payload.
REQ-009 din_valid  input  1  din, din_fix and din_fail are meaningful this cycle.
REQ-010 din_fix  input  1  decoder corrected an error in this word.
REQ-011 din_fail  input  1  decoder detected an uncorrectable error in this word.
REQ-012 clear_counts  input  1  synchronous clear of both statistics counters.
REQ-013 dout  output  32  payload of an accepted word.
REQ-014 dout_ctrl  output  1  control flag (din bit 32) of an accepted word.
REQ-015 dout_valid  output  1  dout/dout_ctrl carry an accepted word this cycle.
REQ-016 slip  output  1  one-cycle request to the upstream aligner to shift word alignment by one bit.
REQ-017 locked  output  1  block is in LOCKED state.
REQ-018 fix_count  output  16  saturating count of corrected words seen while locked.
REQ-019 fail_count  output  16  saturating count of failed words seen while locked.

Function
REQ-020 A word is "good" when din_valid=1 and din_fail=0; "bad" when din_valid=1 and din_fail=1; din_fix is ignored when din_fail=1.
REQ-021 FSM states: HUNT, SLIP_HOLD, LOCKED; only these three are reachable.
REQ-022 HUNT: good word increments good_cnt; when good_cnt reaches LOCK_GOOD on that word, next state LOCKED and good_cnt clears.
REQ-023 HUNT: bad word clears good_cnt, asserts slip for exactly the next cycle, and enters SLIP_HOLD.
REQ-024 SLIP_HOLD: counts SLIP_WAIT clock cycles regardless of din_valid, ignores all inputs, then returns to HUNT with good_cnt=0.
REQ-025 LOCKED: a window counter counts valid words 0..WINDOW-1 and wraps; bad_cnt counts bad words in the current window.
REQ-026 LOCKED: bad_cnt including the current word reaching UNLOCK_BAD forces HUNT next cycle (no slip); window and bad_cnt clear.
REQ-027 LOCKED: on the word that completes a window without reaching UNLOCK_BAD, bad_cnt and window counter clear for the next window.
REQ-028 dout_valid=1 one cycle after a good word accepted in LOCKED state (registered, latency 1); dout=din[31:0], dout_ctrl=din[32].
REQ-029 The word that causes the HUNT->LOCKED transition is not output; the first output word is the next good word.
REQ-030 Bad words in LOCKED produce dout_valid=0; dout holds its previous value whenever dout_valid=0.
REQ-031 fix_count increments on good words with din_fix=1 in LOCKED; fail_count increments on bad words in LOCKED; both saturate at 16'hFFFF.
REQ-032 clear_counts has priority over a same-cycle increment: counter becomes 0.
REQ-033 slip is never asserted in two consecutive cycles; minimum spacing is SLIP_WAIT+1 cycles.
REQ-034 locked is registered and equals (state==LOCKED).

Reset
REQ-035 arst asserted: immediately state=HUNT, all internal counters 0, dout=0, dout_ctrl=0, dout_valid=0, slip=0, locked=0, fix_count=0, fail_count=0.
REQ-036 arst asserted mid-slip or mid-window aborts the operation; no slip pulse is emitted after deassertion until a new bad word in HUNT.
REQ-037 After arst deassertion the first edge may evaluate inputs normally.

Verification
REQ-038 Reset, then 16 good words -> locked=1 the cycle after the 16th; 17th good word appears on dout one cycle later with dout_valid=1.
REQ-039 HUNT with 10 good words then 1 bad -> slip=1 for one cycle, next 8 cycles inputs ignored, good_cnt restarts from 0 (lock needs 16 more).
REQ-040 LOCKED, 3 bad words in a 64-word window -> stays locked, fail_count=3; 4th bad in same window -> locked=0 next cycle, no slip.
REQ-041 LOCKED, 3 bad in window 1 then 3 bad in window 2 -> stays locked, fail_count=6.
REQ-042 Word with din_fix=1 and din_fail=1 while locked -> fail_count+1, fix_count unchanged, dout_valid=0.
REQ-043 fix_count preloaded by 65535 fixed words -> further fixes hold at 16'hFFFF; clear_counts with a simultaneous fix -> 0.
